// File: rtl/rv_fetch_pkg.sv
// ============================================================================
// rv_fetch_pkg : shared widths and FSM encoding for the fetch sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package rv_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_sel.sv
// ============================================================================
// pc_redirect_sel : redirect priority, JALR LSB masking, target alignment
// Revision 1.0  (MISALIGN_TRAP_EN: report misaligned targets instead of forcing)
// ============================================================================
`default_nettype none

module pc_redirect_sel import rv_fetch_pkg::*; #(
  parameter int N = XLEN
) (
  input  logic         branch_taken,
  input  logic [N-1:0] pc_signed_offset,
  input  logic         jalr,
  input  logic [N-1:0] jalr_target,
  output logic [N-1:0] tgt,
  output logic         redirect
`ifdef MISALIGN_TRAP_EN
  ,
  output logic         misaligned
`endif
);

  logic [N-1:0] sel;
  logic         unused_bits;

  // jalr has priority; its target LSB is cleared before any alignment check
  assign sel      = jalr ? {jalr_target[N-1:1], 1'b0} : pc_signed_offset;
  assign redirect = jalr | branch_taken;

`ifdef MISALIGN_TRAP_EN
  assign tgt         = sel;
  assign misaligned  = redirect & sel[1];
  assign unused_bits = jalr_target[0];
`else
  assign tgt         = {sel[N-1:2], 2'b00};
  assign unused_bits = jalr_target[0] ^ (^sel[1:0]);
`endif

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// pc_fetch_ctrl : architectural PC owner and req/ready instruction fetch FSM
// Revision 1.0  (MISALIGN_TRAP_EN: misaligned redirects load TRAP_VEC)
// ============================================================================
`default_nettype none

module pc_fetch_ctrl import rv_fetch_pkg::*; #(
  parameter int           N        = XLEN,
  parameter logic [N-1:0] RESET_PC = '0
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [N-1:0] TRAP_VEC = N'('h100)
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         branch_taken,
  input  logic [N-1:0] pc_signed_offset,
  input  logic         jalr,
  input  logic [N-1:0] jalr_target,
  input  logic         stall,
  input  logic         imem_ready,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         fetch_valid,
  output logic [N-1:0] fetch_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic         misalign_trap
`endif
);

  fetch_state_t state, state_nxt;
  logic         redirect;
  logic         handshake;
  logic         direct_load;
  logic         pending;
  logic [N-1:0] pend_tgt;
  logic [N-1:0] sel_tgt;
  logic [N-1:0] tgt;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic pend_mis;

  pc_redirect_sel #(.N(N)) u_sel (
    .branch_taken     (branch_taken),
    .pc_signed_offset (pc_signed_offset),
    .jalr             (jalr),
    .jalr_target      (jalr_target),
    .tgt              (sel_tgt),
    .redirect         (redirect),
    .misaligned       (misaligned)
  );

  assign tgt = misaligned ? TRAP_VEC : sel_tgt;
`else
  pc_redirect_sel #(.N(N)) u_sel (
    .branch_taken     (branch_taken),
    .pc_signed_offset (pc_signed_offset),
    .jalr             (jalr),
    .jalr_target      (jalr_target),
    .tgt              (sel_tgt),
    .redirect         (redirect)
  );

  assign tgt = sel_tgt;
`endif

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_RESET: state_nxt = S_ISSUE;
      S_ISSUE: begin
        imem_req = ~stall;
        if (!stall && !imem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  assign imem_addr   = pc;
  assign pc_plus4    = pc + N'(INSTR_BYTES);
  assign handshake   = imem_req & imem_ready;
  // Nothing is in flight, so a redirect can move the PC right away
  assign direct_load = (state == S_ISSUE) && stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      pending     <= 1'b0;
      pend_tgt    <= RESET_PC;
    end else begin
      state       <= state_nxt;
      fetch_valid <= handshake;
      if (handshake) begin
        fetch_pc <= pc;
        pending  <= 1'b0;
        if (pending)       pc <= pend_tgt;
        else if (redirect) pc <= tgt;
        else               pc <= pc_plus4;
      end else if (redirect) begin
        if (direct_load) begin
          pc      <= tgt;
          pending <= 1'b0;
        end else begin
          pend_tgt <= tgt;
          pending  <= 1'b1;
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Trap pulse accompanies the PC update that consumes the misaligned target
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_trap <= 1'b0;
      pend_mis      <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      if (handshake) begin
        misalign_trap <= pending ? pend_mis : (redirect & misaligned);
        pend_mis      <= 1'b0;
      end else if (redirect) begin
        if (direct_load) begin
          misalign_trap <= misaligned;
          pend_mis      <= 1'b0;
        end else begin
          pend_mis <= misaligned;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// tb_pc_fetch_ctrl : directed + random bench against a transaction-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] pc_signed_offset = '0;
  logic        jalr = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .branch_taken     (branch_taken),
    .pc_signed_offset (pc_signed_offset),
    .jalr             (jalr),
    .jalr_target      (jalr_target),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_trap    (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding-request flag plus a queue of redirects
  // waiting for the in-flight fetch; the newest queued redirect wins.
  bit          m_known = 0;
  bit          m_booting;
  bit          m_outstanding;
  logic [31:0] m_pc, m_fpc;
  bit          m_fv, m_trap;
  logic [32:0] m_redir_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic br, input logic [31:0] off,
                       input logic jr, input logic [31:0] jt,
                       input logic st, input logic rd);
    bit          want_req, hs, redir, tr, use_trap;
    logic [31:0] t, nxt_pc;
    rst = r; branch_taken = br; pc_signed_offset = off;
    jalr = jr; jalr_target = jt; stall = st; imem_ready = rd;
    #1;
    want_req = !m_booting && (m_outstanding || !st);
    if (m_known) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, want_req});
      if (want_req) chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
      chk("fetch_pc", fetch_pc, m_fpc);
`ifdef MISALIGN_TRAP_EN
      chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
`endif
    end
    redir = jr || br;
    t     = jr ? (jt & 32'hFFFF_FFFE) : off;
`ifdef MISALIGN_TRAP_EN
    tr = redir && t[1];
    if (tr) t = TRAP;
`else
    tr = 1'b0;
    t  = t & 32'hFFFF_FFFC;
`endif
    hs = want_req && rd;
    use_trap = 1'b0;
    if (r) begin
      m_known = 1; m_booting = 1; m_outstanding = 0;
      m_pc = 32'h0; m_fpc = 32'h0; m_fv = 0;
      m_redir_q.delete();
    end else begin
      m_fv = hs;
      if (hs) begin
        m_fpc = m_pc;
        if (m_redir_q.size() > 0) begin
          nxt_pc = m_redir_q[$][31:0];
          use_trap = m_redir_q[$][32];
        end else if (redir) begin
          nxt_pc = t; use_trap = tr;
        end else begin
          nxt_pc = m_pc + 32'd4;
        end
        m_pc = nxt_pc;
        m_redir_q.delete();
        m_outstanding = 0;
      end else begin
        if (redir) begin
          if (!m_booting && !m_outstanding && st) begin
            m_pc = t; use_trap = tr;
            m_redir_q.delete();
          end else begin
            m_redir_q.push_back({tr, t});
          end
        end
        m_outstanding = want_req;
      end
      m_booting = 0;
    end
    m_trap = use_trap && !r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st, input logic rd);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, st, rd);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    // 1: reset, then back-to-back fetches 0,4,8,C
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    idle(1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b1);
    chk("seq_pc", pc, 32'h10);
    chk("seq_fetch_pc", fetch_pc, 32'hC);

    // 2: ready low for 3 cycles at pc=8
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    repeat (3) idle(1'b0, 1'b0);
    chk("wait_addr", imem_addr, 32'h8);
    idle(1'b0, 1'b1);
    chk("wait_fetch_pc", fetch_pc, 32'h8);
    chk("wait_pc", pc, 32'hC);

    // 3: branch to 0x40 during WAIT at pc=8
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    chk("pend_pc", pc, 32'h40);
    chk("pend_fetch_pc", fetch_pc, 32'h8);
    idle(1'b0, 1'b1);

    // 4: jalr and branch together, jalr wins and its LSB is cleared
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h101, 1'b0, 1'b1);
    chk("jalr_pc", pc, 32'h100);

    // 5: PC wraps past the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    idle(1'b0, 1'b1);
    chk("wrap_pc", pc, 32'h0);

    // 6: misaligned branch to 0x42 while stalled
    cycle(1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'h100);
    chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
    idle(1'b1, 1'b1);
    chk("mis_trap_clr", {31'd0, misalign_trap}, 32'd0);
`else
    chk("mis_pc", pc, 32'h40);
    idle(1'b1, 1'b1);
`endif

    // Reset while waiting with a pending redirect
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_req", {31'd0, imem_req}, 32'd0);
    chk("rstw_pc", pc, 32'h0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    chk("rstw_no_pend", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 4) == 0), $urandom,
            ($urandom_range(0, 6) == 0), $urandom,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0));
    end
    idle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
